// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_controller
//  Purpose  : Bridges MEM-stage data accesses onto an external 16-bit
//             asynchronous SRAM. A 32-bit word is transferred as two 16-bit
//             halves (low half first), each held on the bus for WAIT_CYCLES
//             clocks. While an access is in flight `ready` is low, and the
//             pipeline uses it as its freeze signal.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WAIT_CYCLES  cycles each half-access is held on the bus (1..15)
//    BASE_ADDR    byte address that maps to SRAM word 0
//    SRAM_AW      SRAM address width in 16-bit locations
//  Ports
//    clk, rst          clock, synchronous active-high reset
//    rd_en, wr_en      MEM-stage load / store request (store wins if both)
//    address           byte address (ALU result), bits [1:0] ignored
//    write_data        store data
//    read_data         assembled load data, held until the next load
//    ready             low while an access is pending
//    sram_addr         SRAM location {word index, half}
//    sram_dq_out       data driven onto the SRAM DQ pads
//    sram_dq_in        data returned from the SRAM DQ pads
//    sram_dq_oe        DQ pad output enable (1 = drive)
//    sram_we_n         SRAM write strobe, active-low
//  Optional feature (macro SRAM_CTRL_STATS_EN)
//    rd_count, wr_count  16-bit wrapping counts of completed loads / stores
// ============================================================================
module sram_mem_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
`ifdef SRAM_CTRL_STATS_EN
   output logic [15:0]        rd_count,
   output logic [15:0]        wr_count,
`endif
   output logic               sram_we_n
);

   // Word index occupies every SRAM address bit except the half selector.
   localparam int         IDX_W    = SRAM_AW - 1;
   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic             op_write;
   logic [IDX_W-1:0] word_idx_q;
   logic [15:0]      wdata_hi_q;

   logic             req;
   logic [31:0]      addr_diff;
   logic [IDX_W-1:0] word_idx;
   logic             phase_end;

   assign req       = rd_en | wr_en;
   // Out-of-window addresses wrap silently through the truncation.
   assign addr_diff = address - BASE_ADDR;
   assign word_idx  = IDX_W'(addr_diff >> 2);
   assign phase_end = (wait_cnt == LAST_CNT);

   // In IDLE, a request drops ready in the same cycle so the pipeline
   // freezes before the access is even launched.
   assign ready = (state == S_DONE) || ((state == S_IDLE) && !req);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= 4'd0;
         op_write    <= 1'b0;
         word_idx_q  <= '0;
         wdata_hi_q  <= 16'd0;
         read_data   <= 32'd0;
         sram_addr   <= '0;
         sram_dq_out <= 16'd0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
`ifdef SRAM_CTRL_STATS_EN
         rd_count    <= 16'd0;
         wr_count    <= 16'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  // Latch the whole request; later changes on the inputs
                  // are ignored until the access completes.
                  op_write   <= wr_en;
                  word_idx_q <= word_idx;
                  wdata_hi_q <= write_data[31:16];
                  wait_cnt   <= 4'd0;
                  state      <= S_LOW;
                  sram_addr  <= {word_idx, 1'b0};
                  sram_dq_oe <= wr_en;
                  sram_we_n  <= ~wr_en;
                  if (wr_en) begin
                     sram_dq_out <= write_data[15:0];
                  end
               end
            end

            S_LOW: begin
               if (phase_end) begin
                  wait_cnt  <= 4'd0;
                  state     <= S_HIGH;
                  sram_addr <= {word_idx_q, 1'b1};
                  if (op_write) begin
                     sram_dq_out <= wdata_hi_q;
                  end else begin
                     read_data[15:0] <= sram_dq_in;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            S_HIGH: begin
               if (phase_end) begin
                  wait_cnt   <= 4'd0;
                  state      <= S_DONE;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!op_write) begin
                     read_data[31:16] <= sram_dq_in;
                  end
`ifdef SRAM_CTRL_STATS_EN
                  // Counted on entry to DONE, so the new value is visible
                  // during the DONE cycle; a reset here wins and skips it.
                  if (op_write) begin
                     wr_count <= wr_count + 16'd1;
                  end else begin
                     rd_count <= rd_count + 16'd1;
                  end
`endif
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_mem_controller
//  Purpose  : Self-checking bench for sram_mem_controller. A table of
//             accesses is applied through a bus-checking task; expected load
//             data is queued when each request is driven and compared when
//             the controller reaches its DONE cycle. Hand-written sequences
//             cover reset, read-data hold, reset abort and the optional
//             statistics counters (SRAM_CTRL_STATS_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_mem_controller;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
`ifdef SRAM_CTRL_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   sram_mem_controller #(
      .WAIT_CYCLES (W),
      .BASE_ADDR   (32'd1024),
      .SRAM_AW     (18)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
`ifdef SRAM_CTRL_STATS_EN
      .rd_count    (rd_count),
      .wr_count    (wr_count),
`endif
      .sram_we_n   (sram_we_n)
   );

   always #5 clk = ~clk;

   // Simple asynchronous SRAM model (low 8 address bits are enough here).
   logic [15:0] mem [0:255];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'd0;
   end
   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
   end
   assign sram_dq_in = mem[sram_addr[7:0]];

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: a DONE cycle is the only time ready is high while a
   // request is still being presented.
   always @(negedge clk) begin
      if (!rst && (rd_en || wr_en) && ready) begin
         if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            automatic logic [31:0] e = sb_q.pop_front();
            chk("read_data_at_done", read_data, e);
         end
      end
   end

   // One access: drive, check every bus cycle, check freeze length.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [17:0] lo,
                            input logic [31:0] exp_rd);
      int n;
      logic hi;
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; address = a; write_data = wd;
      sb_q.push_back(exp_rd);
      n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         if (n >= 1) begin
            hi = (n > W);
            chk("sram_addr", {14'd0, sram_addr}, {14'd0, lo[17:1], hi});
            chk("sram_we_n", {31'd0, sram_we_n}, {31'd0, ~wr});
            chk("sram_dq_oe", {31'd0, sram_dq_oe}, {31'd0, wr});
            if (wr) chk("sram_dq_out", {16'd0, sram_dq_out}, {16'd0, hi ? wd[31:16] : wd[15:0]});
         end
         n++;
         @(negedge clk);
      end
      chk("freeze_cycles", n, 2 * W + 1);
      chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("done_oe", {31'd0, sram_dq_oe}, 32'd0);
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] exp_lo_addr;
      logic [31:0] exp_rdata;
      int          hold;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h00000000, 0};
      vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,       32'hDEADBEEF, 10};
      vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0,       32'hDEADBEEF, 2};
      vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0,       32'h12345678, 0};
      vecs[4] = '{1'b0, 1'b1, 32'd1031, 32'hA5A55A5A, 18'd2,       32'h12345678, 0};
      vecs[5] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,       32'hA5A55A5A, 0};
      vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   32'hA5A55A5A, 0};
      vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 18'h3FFFE,   32'hCAFEF00D, 0};
      vecs[8] = '{1'b1, 1'b0, 32'd1044, 32'h00000000, 18'd10,      32'h00000000, 0};

      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("reset_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("reset_read_data", read_data, 32'd0);
      chk("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
      chk("reset_dq_out", {16'd0, sram_dq_out}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_lo_addr, vecs[i].exp_rdata);
         for (int k = 0; k < vecs[i].hold; k++) begin
            @(negedge clk);
            chk("read_data_hold", read_data, vecs[i].exp_rdata);
            chk("idle_ready", {31'd0, ready}, 32'd1);
         end
      end

      // Reset in the second HIGH cycle of a write aborts it.
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
      repeat (2 * W) @(posedge clk);
      @(negedge clk);
      chk("abort_pre_we_n", {31'd0, sram_we_n}, 32'd0);
      chk("abort_pre_addr", {14'd0, sram_addr}, 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("abort_ready_idle_rule", {31'd0, ready}, 32'd0);
      wr_en = 1'b0;
      #1;
      chk("abort_ready_released", {31'd0, ready}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_abort_we_n", {31'd0, sram_we_n}, 32'd1);
      end
      chk("read_data_after_abort", read_data, 32'd0);

`ifdef SRAM_CTRL_STATS_EN
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("stats_reset_rd", {16'd0, rd_count}, 32'd0);
      chk("stats_reset_wr", {16'd0, wr_count}, 32'd0);
      do_access(1'b0, 1'b1, 32'd1024, 32'h0F0F0F0F, 18'd0, 32'h00000000);
      do_access(1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0, 32'h0F0F0F0F);
      do_access(1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2, 32'hA5A55A5A);
      do_access(1'b0, 1'b1, 32'd1028, 32'h33334444, 18'd2, 32'hA5A55A5A);
      do_access(1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2, 32'h33334444);
      @(negedge clk);
      chk("stats_rd_count", {16'd0, rd_count}, 32'd3);
      chk("stats_wr_count", {16'd0, wr_count}, 32'd2);
      force dut.wr_count = 16'hFFFF;
      #1 release dut.wr_count;
      do_access(1'b0, 1'b1, 32'd1036, 32'h55556666, 18'd6, 32'h33334444);
      @(negedge clk);
      chk("stats_wr_wrap", {16'd0, wr_count}, 32'd0);
      chk("stats_rd_after_wrap", {16'd0, rd_count}, 32'd3);
`endif

      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
